ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port round-robin arbiter in front of a single-port RAM with
// asynchronous read data. Each access takes three cycles (IDLE -> ACC -> DONE):
// the winner's request is latched in IDLE, the RAM is accessed in ACC, and the
// winner is acknowledged in DONE.
//
// Parameters
//   AW      RAM address width
//   DW      RAM data width
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous active-high reset
//   req0/req1   access request, held until the matching ack
//   we0/we1     1 = write, 0 = read
//   a0/a1       access address
//   d0/d1       write data
//   gnt0/gnt1   requester owns the RAM (ACC and DONE)
//   ack0/ack1   one-cycle completion pulse (DONE)
//   rdata       read result, valid in the ack cycle, held until the next access
//   ram_we      RAM write enable (ACC only, for a latched write)
//   ram_a       RAM address
//   ram_d       RAM write data
//   ram_spo     RAM asynchronous read data for ram_a
module ram_arbiter #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] a0,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] d0,
  input  logic [DW-1:0] d1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_spo
);

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic          win_q, win_d;     // 0 = requester 0 owns the access, 1 = requester 1
  logic          last_q, last_d;   // requester served last, for round-robin ties
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          any_req;
  logic          pick1;

  // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
  assign any_req = req0 | req1;
  assign pick1   = req1 & (~req0 | ~last_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d = StAcc;
        end
      end
      StAcc:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (decoded from state only, so reset clears them immediately)
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    ack0   = 1'b0;
    ack1   = 1'b0;
    ram_we = 1'b0;
    unique case (state_q)
      StIdle: ;
      StAcc: begin
        gnt0   = ~win_q;
        gnt1   = win_q;
        ram_we = we_q;
      end
      StDone: begin
        gnt0 = ~win_q;
        gnt1 = win_q;
        ack0 = ~win_q;
        ack1 = win_q;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: request latch, read capture and round-robin pointer
  // ---------------------------------------------------------------------------
  always_comb begin
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          win_d   = pick1;
          we_d    = pick1 ? we1 : we0;
          addr_d  = pick1 ? a1  : a0;
          wdata_d = pick1 ? d1  : d0;
        end
      end
      StAcc: begin
        // Captured at the same edge as the RAM write, so a write returns the old data.
        rdata_d = ram_spo;
      end
      StDone: begin
        last_d = win_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ram_a = addr_q;
  assign ram_d = wdata_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter. A behavioural RAM hangs off the RAM
// port; a reference memory predicts read data. Expected (port, rdata) pairs are
// queued when requests are driven and popped by a monitor on every ack.
module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          gnt0, gnt1, ack0, ack1;
  logic [DW-1:0] rdata;
  logic          ram_we;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d;
  logic [DW-1:0] ram_spo;

  logic [DW-1:0] mem     [2**AW];
  logic [DW-1:0] ref_mem [2**AW];

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic prev_ack0 = 1'b0;
  logic prev_ack1 = 1'b0;

  ram_arbiter #(
    .AW(AW),
    .DW(DW)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .we0    (we0),
    .we1    (we1),
    .a0     (a0),
    .a1     (a1),
    .d0     (d0),
    .d1     (d1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .ack0   (ack0),
    .ack1   (ack1),
    .rdata  (rdata),
    .ram_we (ram_we),
    .ram_a  (ram_a),
    .ram_d  (ram_d),
    .ram_spo(ram_spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: asynchronous read, write on the rising edge.
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
  end
  assign ram_spo = mem[ram_a];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every ack must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt0 | gnt1) check_eq("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
      if (ack0 | ack1) begin
        check_eq("ack_excl", {31'd0, ack0 & ack1}, 32'd0);
        if (ack0) check_eq("ack0_pulse", {31'd0, prev_ack0}, 32'd0);
        if (ack1) check_eq("ack1_pulse", {31'd0, prev_ack1}, 32'd0);
        check_eq("ack_expected", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check_eq("ack_port", ack1 ? 32'd1 : 32'd0, e.port);
          check_eq("rdata", {24'd0, rdata}, {24'd0, e.data});
        end
      end
    end
    prev_ack0 = ack0;
    prev_ack1 = ack1;
  end

  task automatic expect_access(input int port, input logic we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
    exp_t e;
    e.port = port;
    e.data = ref_mem[a];
    sb.push_back(e);
    if (we) ref_mem[a] = d;
  endtask

  task automatic drive(input int port, input logic req, input logic we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port == 0) begin
      req0 = req; we0 = we; a0 = a; d0 = d;
    end else begin
      req1 = req; we1 = we; a1 = a; d1 = d;
    end
  endtask

  // Single uncontended access, started in an IDLE cycle; checks the ACC cycle
  // contents and that ack arrives in the third cycle counting the request cycle.
  task automatic access(input int port, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    int cyc;
    bit seen;
    @(negedge clk);
    expect_access(port, we, a, d);
    drive(port, 1'b1, we, a, d);
    cyc  = 1;
    seen = 1'b0;
    @(negedge clk);
    cyc++;
    check_eq("acc_gnt", {31'd0, (port == 0) ? gnt0 : gnt1}, 32'd1);
    check_eq("acc_ram_we", {31'd0, ram_we}, {31'd0, we});
    check_eq("acc_ram_a", {28'd0, ram_a}, {28'd0, a});
    if (we) check_eq("acc_ram_d", {24'd0, ram_d}, {24'd0, d});
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if ((port == 0 && ack0) || (port == 1 && ack1)) seen = 1'b1;
    end
    check_eq("ack_seen", {31'd0, seen}, 32'd1);
    check_eq("ack_latency", cyc, 32'd3);
    check_eq("done_ram_we", {31'd0, ram_we}, 32'd0);
    drive(port, 1'b0, 1'b0, '0, '0);
  endtask

  // Both requesters assert together; a requester releases on its own ack
  // unless hold is set. Returns after n acks (or a cycle budget).
  task automatic tie(input int n, input bit hold, input logic [AW-1:0] x0,
                     input logic [AW-1:0] x1);
    int acks;
    int cyc;
    @(negedge clk);
    for (int i = 0; i < n; i++) expect_access(i % 2, 1'b0, (i % 2 == 0) ? x0 : x1, '0);
    drive(0, 1'b1, 1'b0, x0, '0);
    drive(1, 1'b1, 1'b0, x1, '0);
    acks = 0;
    cyc  = 0;
    while (acks < n && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ack0 | ack1) begin
        acks++;
        if (!hold && ack0) req0 = 1'b0;
        if (!hold && ack1) req1 = 1'b0;
      end
    end
    check_eq("tie_acks", acks, n);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]     = DW'(8'h10 + i * 3);
      ref_mem[i] = DW'(8'h10 + i * 3);
    end
    mem[4'hB]     = 8'hF1;
    ref_mem[4'hB] = 8'hF1;

    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_outs", {26'd0, gnt0, gnt1, ack0, ack1, ram_we, 1'b0}, 32'd0);
    check_eq("rst_ram_a", {28'd0, ram_a}, 32'd0);
    check_eq("rst_ram_d", {24'd0, ram_d}, 32'd0);
    check_eq("rst_rdata", {24'd0, rdata}, 32'd0);
    rst = 1'b0;

    // Held tie out of reset: 0, 1, 0, 1.
    tie(4, 1'b1, 4'h1, 4'h2);

    // Write then read back from the other port.
    access(0, 1'b1, 4'hA, 8'h23);
    access(1, 1'b0, 4'hA, 8'h00);

    // Read-during-write returns old data; later read sees new data.
    access(0, 1'b1, 4'hB, 8'h90);
    access(0, 1'b0, 4'hB, 8'h00);

    // Address extremes.
    access(1, 1'b1, 4'hF, 8'h5A);
    access(0, 1'b1, 4'h0, 8'hA5);
    access(0, 1'b0, 4'hF, 8'h00);
    access(1, 1'b0, 4'h0, 8'h00);

    // req1 dropped in ACC: access still completes, then the FSM idles.
    @(negedge clk);
    expect_access(1, 1'b0, 4'h3, '0);
    drive(1, 1'b1, 1'b0, 4'h3, '0);
    @(negedge clk);
    check_eq("drop_acc_gnt1", {31'd0, gnt1}, 32'd1);
    req1 = 1'b0;
    @(negedge clk);
    check_eq("drop_ack1", {31'd0, ack1}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      check_eq("drop_idle", {29'd0, ram_we, gnt0, gnt1}, 32'd0);
    end

    // Reset during ACC of a write to 0xC: no ack, outputs cleared, no write.
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 4'hC, 8'h77);
    @(negedge clk);
    check_eq("pre_rst_ram_we", {31'd0, ram_we}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_acc_outs", {27'd0, gnt0, gnt1, ack0, ack1, ram_we}, 32'd0);
    check_eq("rst_acc_ram_a", {28'd0, ram_a}, 32'd0);
    check_eq("rst_acc_rdata", {24'd0, rdata}, 32'd0);
    req0 = 1'b0;
    @(negedge clk);
    check_eq("rst_no_write", {24'd0, mem[4'hC]}, {24'd0, ref_mem[4'hC]});
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_no_ack", {30'd0, ack0, ack1}, 32'd0);
    end

    // Pointer back to 1: requester 0 wins the next tie.
    tie(2, 1'b0, 4'h4, 4'h5);
    access(1, 1'b0, 4'hC, 8'h00);

    repeat (3) @(negedge clk);
    check_eq("sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
